btn_debounce: RTL

//  Cleans one raw mechanical switch/button into a glitch-free edge strobe for the

---
 rtl/btn_debounce.sv | 127 ++++++++++++
 1 files changed

// File: rtl/btn_debounce.sv
// Button debouncer: 2-flop synchronizer, stable-count FSM and hold-to-repeat.
// Produces a clean level plus registered press/release strobes and a press counter.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned HOLD_CYCLES     = 32'h4C4B40,
  parameter int unsigned REPEAT_CYCLES   = 32'h0F4240,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter bit          ACTIVE_LOW      = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [7:0] press_count
);

  localparam int unsigned MAX_DH =
    (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int unsigned MAX_P =
    (MAX_DH > REPEAT_CYCLES) ? MAX_DH : REPEAT_CYCLES;
  localparam int CW = $clog2(MAX_P);

  localparam logic [CW-1:0] D_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] H_RELOAD = CW'(HOLD_CYCLES - REPEAT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync;
  logic          s;
  logic [CW-1:0] dcnt, dcnt_n;
  logic [CW-1:0] hcnt, hcnt_n;
  logic          level_n;
  logic          press_n;
  logic          release_n;

  assign s = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= '0;
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      sync          <= {sync[0], btn_raw ^ ACTIVE_LOW};
      state         <= state_n;
      dcnt          <= dcnt_n;
      hcnt          <= hcnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      if (press_n) begin
        press_count <= press_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    dcnt_n    = dcnt;
    hcnt_n    = hcnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    unique case (state)
      IDLE: begin
        level_n = 1'b0;
        if (s) begin
          state_n = PRESS_WAIT;
          dcnt_n  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_n = IDLE;
        end else if (dcnt == D_LAST) begin
          state_n = PRESSED;
          level_n = 1'b1;
          press_n = 1'b1;
          hcnt_n  = '0;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_n = RELEASE_WAIT;
          dcnt_n  = '0;
        end else if (REPEAT_EN) begin
          // reload keeps the repeat period without a second counter
          if (hcnt == H_LAST) begin
            press_n = 1'b1;
            hcnt_n  = H_RELOAD;
          end else begin
            hcnt_n = hcnt + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_n = PRESSED;
        end else if (dcnt == D_LAST) begin
          state_n   = IDLE;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          dcnt_n = dcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
